// File: rtl/pwm_peripheral_pkg.sv
// pwm_peripheral_pkg: shared constants for the 16-channel PWM peripheral
package pwm_peripheral_pkg;
  localparam int PWM_RES = 8;
  localparam logic [PWM_RES-1:0] DUTY_FULL = 8'hFF;
  localparam int NUM_CH = 16;
endpackage

// File: rtl/pwm_timebase.sv
// pwm_timebase: prescaler plus 8-bit PWM counter shared by all channels
module pwm_timebase
  import pwm_peripheral_pkg::*;
#(
  parameter int PRESCALE = 13
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PWM_RES-1:0] counter,
  output logic               tick,
  output logic               wrap
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] pre;
  assign tick = pre == PW'(PRESCALE - 1);
  // wrap marks the terminal count; the 255 -> 0 step happens on wrap && tick
  assign wrap = counter == {PWM_RES{1'b1}};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pre     <= '0;
      counter <= '0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) counter <= counter + 1'b1;
    end
endmodule

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: 16 output pins, each off, static high or PWM from one shared duty
module pwm_peripheral
  import pwm_peripheral_pkg::*;
#(
  parameter int PRESCALE        = 13,
  parameter int RESOLUTION_BITS = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        en_reg_out_7_0,
  input  logic [7:0]        en_reg_out_15_8,
  input  logic [7:0]        en_reg_pwm_7_0,
  input  logic [7:0]        en_reg_pwm_15_8,
  input  logic [7:0]        pwm_duty_cycle,
  output logic [NUM_CH-1:0] out,
  output logic              period_start
);
  logic [RESOLUTION_BITS-1:0] counter;
  logic [RESOLUTION_BITS-1:0] duty_shadow;
  logic tick, wrap, level;
  logic [NUM_CH-1:0] en_out, en_pwm;
  pwm_timebase #(.PRESCALE(PRESCALE)) u_timebase (
    .clk    (clk),
    .rst_n  (rst_n),
    .counter(counter),
    .tick   (tick),
    .wrap   (wrap)
  );
  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  // duty 0 never satisfies counter < duty, so 0% is glitch-free by construction
  assign level = duty_shadow == DUTY_FULL || counter < duty_shadow;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      duty_shadow  <= '0;
      out          <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= tick && wrap;
      if (tick && wrap) duty_shadow <= pwm_duty_cycle;
      out <= en_out & (~en_pwm | {NUM_CH{level}});
    end
endmodule

// File: tb/tb_pwm_peripheral.sv
// tb_pwm_peripheral: cycle-by-cycle model compare plus directed duty/enable/reset scenarios
module tb_pwm_peripheral;
  localparam int P   = 13;
  localparam int PER = 256 * P;
  logic clk = 0, rst_n = 0;
  logic [7:0] eo_lo = 0, eo_hi = 0, ep_lo = 0, ep_hi = 0, duty = 0;
  logic [15:0] out;
  logic period_start;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  pwm_peripheral #(.PRESCALE(P), .RESOLUTION_BITS(8)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_reg_out_7_0 (eo_lo),
    .en_reg_out_15_8(eo_hi),
    .en_reg_pwm_7_0 (ep_lo),
    .en_reg_pwm_15_8(ep_hi),
    .pwm_duty_cycle (duty),
    .out            (out),
    .period_start   (period_start)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // model: n = clk edges since reset release; counter = (n/P) mod 256; a period ends every PER edges
  longint n;
  logic [7:0] m_shadow;
  logic [15:0] m_out;
  logic m_ps;
  function automatic logic lvl_f(longint k, logic [7:0] s);
    return s == 8'hFF || ((k / P) % 256) < longint'(s);
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      n <= 0;
      m_shadow <= 0;
      m_out <= 0;
      m_ps <= 0;
    end else begin
      m_out <= {eo_hi, eo_lo} & (~{ep_hi, ep_lo} | {16{lvl_f(n, m_shadow)}});
      n <= n + 1;
      m_ps <= ((n + 1) % PER) == 0;
      if (((n + 1) % PER) == 0) m_shadow <= duty;
    end
  always @(negedge clk) begin
    chk("model_out", out, m_out);
    chk("model_period_start", period_start, m_ps);
  end
  task automatic wait_ps(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!period_start && k < PER + 100);
  endtask
  task automatic count_hi(int idx, int chg_at, logic [7:0] nd, output int c);
    c = 0;
    for (int i = 0; i < PER; i++) begin
      @(negedge clk);
      c += int'(out[idx]);
      if (i == chg_at) duty = nd;
    end
  endtask
  initial begin
    int k, c;
    duty = 8'h80;
    repeat (3) @(negedge clk);
    chk("reset_out", out, 0);
    chk("reset_ps", period_start, 0);
    rst_n = 1;
    wait_ps(k);
    chk("first_ps_gap", k, PER);
    wait_ps(k);
    chk("second_ps_gap", k, PER);
    chk("disabled_out", out, 0);
    {eo_hi, eo_lo} = 16'hFFFF;
    {ep_hi, ep_lo} = 16'h0000;
    @(negedge clk);
    chk("static_on_latency", out, 16'hFFFF);
    {eo_hi, eo_lo} = 16'h0001;
    {ep_hi, ep_lo} = 16'h0001;
    duty = 8'h40;
    wait_ps(k);
    chk("ps_before_duty40", period_start, 1);
    count_hi(0, -1, 8'h00, c);
    chk("duty40_high", c, 832);
    {eo_hi, eo_lo} = 16'h8000;
    {ep_hi, ep_lo} = 16'h8000;
    duty = 8'h00;
    wait_ps(k);
    chk("ps_before_duty00", period_start, 1);
    duty = 8'hFF;
    count_hi(15, -1, 8'h00, c);
    chk("duty00_high", c, 0);
    count_hi(15, -1, 8'h00, c);
    chk("dutyFF_high", c, PER);
    {eo_hi, eo_lo} = 16'h0001;
    {ep_hi, ep_lo} = 16'h0001;
    duty = 8'h40;
    wait_ps(k);
    chk("ps_before_midchange", period_start, 1);
    count_hi(0, 100 * P - 1, 8'hC0, c);
    chk("midchange_keeps_40", c, 832);
    count_hi(0, -1, 8'h00, c);
    chk("next_period_C0", c, 2496);
    {eo_hi, eo_lo} = 16'hFFFF;
    {ep_hi, ep_lo} = 16'h0000;
    repeat (500) @(negedge clk);
    chk("pre_reset_out", out, 16'hFFFF);
    #3 rst_n = 0;
    #1;
    chk("async_reset_out", out, 0);
    chk("async_reset_ps", period_start, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    wait_ps(k);
    chk("ps_gap_after_reset", k, PER);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
